sh7604_intc: RTL and testbench



---
 rtl/sh7604_intc.sv | 259 +++++++++++++++++++++++++
 tb/tb_sh7604_intc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sh7604_intc.sv
// SH7604 interrupt controller: priority arbitration, CPU acknowledge handshake, ICR/IPRA/IPRB.
// Optional build macro SH7604_INTC_EXTVEC_EN adds EXT_VEC, which supplies the IRL vector when ICR.VECMD=1.
// IRL_SYNC sets the synchronizer depth on IRL_N and NMI_N; it must be at least 2.
//
// state | meaning
// IDLE  | no request presented to the CPU
// PEND  | request presented, winner re-evaluated every CE_R
// ACKED | CPU acknowledged, REQ/LVL/VEC frozen until ACK drops
module sh7604_intc #(
    parameter int IRL_SYNC = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    input  logic        NMI_N,
    input  logic [3:0]  IRL_N,
    input  logic        DIVU_IRQ,
    input  logic [7:0]  DIVU_VEC,
    input  logic        DMAC0_IRQ,
    input  logic [7:0]  DMAC0_VEC,
    input  logic        DMAC1_IRQ,
    input  logic [7:0]  DMAC1_VEC,
    input  logic        WDT_IRQ,
    input  logic [7:0]  WDT_VEC,
    input  logic        SCI_IRQ,
    input  logic [7:0]  SCI_VEC,
    input  logic        FRT_IRQ,
    input  logic [7:0]  FRT_VEC,
`ifdef SH7604_INTC_EXTVEC_EN
    input  logic [7:0]  EXT_VEC,
`endif
    output logic        CPU_INT_REQ,
    output logic [3:0]  CPU_INT_LVL,
    output logic        CPU_NMI,
    input  logic        CPU_INT_ACK,
    output logic [7:0]  CPU_INT_VEC
);

    localparam logic [31:0] ADDR_ICR  = 32'hFFFFFEE0;
    localparam logic [31:0] ADDR_IPRB = 32'hFFFFFE60;

    typedef enum logic [1:0] {IDLE, PEND, ACKED} state_t;

    state_t state, state_nx;

    logic                     soft_rst;
    logic                     sel_icr, sel_iprb;
    logic [31:0]              rd_data, reg_do;
    logic                     icr_nmie, icr_vecmd;
    logic [3:0]               ipr_divu, ipr_dma, ipr_wdt, ipr_sci, ipr_frt;
    logic [IRL_SYNC-1:0]      nmi_sync;
    logic [IRL_SYNC-1:0][3:0] irl_sync;
    logic                     nmi_s, nmi_prev, nmi_edge, nmi_pend, nmi_clr;
    logic [3:0]               irl_lvl;
    logic [3:0]               src_lvl [7];
    logic [7:0]               src_vec [7];
    logic [3:0]               best_lvl, win_lvl;
    logic [7:0]               best_vec, win_vec, win_vec_q, ack_vec;
    logic                     best_irl, win_irl, win_any;
    logic                     req_nx, nmi_nx;
    logic [3:0]               lvl_nx;
    logic [7:0]               vec_nx, wvec_nx;
    logic                     unused_bus;

    assign soft_rst  = CE_R & ~RES_N;
    assign sel_icr   = IBUS_REQ & (IBUS_A[31:2] == ADDR_ICR[31:2]);
    assign sel_iprb  = IBUS_REQ & (IBUS_A[31:2] == ADDR_IPRB[31:2]);
    assign IBUS_ACT  = sel_icr | sel_iprb;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_DO   = IBUS_ACT ? reg_do : 32'h0;
    assign nmi_s     = nmi_sync[IRL_SYNC-1];
    assign irl_lvl   = ~irl_sync[IRL_SYNC-1];
    assign nmi_edge  = icr_nmie ? (~nmi_prev & nmi_s) : (nmi_prev & ~nmi_s);

    // ICR occupies the upper half of the EE0 longword, IPRA the lower half
    always_comb begin
        rd_data = 32'h0;
        if (sel_icr)
            rd_data = {nmi_s, 6'b0, icr_nmie, 7'b0, icr_vecmd,
                       ipr_divu, ipr_dma, ipr_wdt, 4'b0};
        else if (sel_iprb)
            rd_data = {ipr_sci, ipr_frt, 24'h0};
    end

`ifdef SH7604_INTC_EXTVEC_EN
    logic win_irl_q;
    assign unused_bus = ^{IBUS_A[1:0], IBUS_DI[23:17], IBUS_DI[3:0]};
    assign ack_vec    = (win_irl_q && icr_vecmd) ? EXT_VEC : win_vec_q;

    always_ff @(posedge CLK) begin
        if (RST || soft_rst)
            win_irl_q <= 1'b0;
        else if (CE_R)
            win_irl_q <= win_irl;
    end
`else
    assign unused_bus = ^{IBUS_A[1:0], IBUS_DI[23:16], IBUS_DI[3:0], IBUS_BA[2]};
    assign ack_vec    = win_vec_q;
    assign icr_vecmd  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST || soft_rst) begin
            icr_nmie <= 1'b0;
            ipr_divu <= 4'h0;
            ipr_dma  <= 4'h0;
            ipr_wdt  <= 4'h0;
            ipr_sci  <= 4'h0;
            ipr_frt  <= 4'h0;
            nmi_sync <= '1;
            irl_sync <= '1;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else if (CE_R) begin
            nmi_sync <= {nmi_sync[IRL_SYNC-2:0], NMI_N};
            irl_sync <= {irl_sync[IRL_SYNC-2:0], IRL_N};
            nmi_prev <= nmi_s;
            // an edge arriving with the clearing ACK must not be lost
            nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_edge;
            if (IBUS_WE && sel_icr) begin
                if (IBUS_BA[3]) icr_nmie <= IBUS_DI[24];
                if (IBUS_BA[1]) begin
                    ipr_divu <= IBUS_DI[15:12];
                    ipr_dma  <= IBUS_DI[11:8];
                end
                if (IBUS_BA[0]) ipr_wdt <= IBUS_DI[7:4];
            end
            if (IBUS_WE && sel_iprb && IBUS_BA[3]) begin
                ipr_sci <= IBUS_DI[31:28];
                ipr_frt <= IBUS_DI[27:24];
            end
        end
    end

`ifdef SH7604_INTC_EXTVEC_EN
    always_ff @(posedge CLK) begin
        if (RST || soft_rst)
            icr_vecmd <= 1'b0;
        else if (CE_R && IBUS_WE && sel_icr && IBUS_BA[2])
            icr_vecmd <= IBUS_DI[16];
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST || soft_rst)
            reg_do <= 32'h0;
        else if (CE_F && IBUS_ACT && !IBUS_WE)
            reg_do <= rd_data;
    end

    // index order doubles as the tie-break order; IPR=0 yields level 0 = no request
    always_comb begin
        src_lvl[0] = irl_lvl;
        src_vec[0] = 8'd64 + {5'b0, irl_lvl[3:1]};
        src_lvl[1] = DIVU_IRQ  ? ipr_divu : 4'h0;
        src_vec[1] = DIVU_VEC;
        src_lvl[2] = DMAC0_IRQ ? ipr_dma  : 4'h0;
        src_vec[2] = DMAC0_VEC;
        src_lvl[3] = DMAC1_IRQ ? ipr_dma  : 4'h0;
        src_vec[3] = DMAC1_VEC;
        src_lvl[4] = WDT_IRQ   ? ipr_wdt  : 4'h0;
        src_vec[4] = WDT_VEC;
        src_lvl[5] = SCI_IRQ   ? ipr_sci  : 4'h0;
        src_vec[5] = SCI_VEC;
        src_lvl[6] = FRT_IRQ   ? ipr_frt  : 4'h0;
        src_vec[6] = FRT_VEC;
        best_lvl = 4'h0;
        best_vec = 8'h0;
        best_irl = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (src_lvl[i] > best_lvl) begin
                best_lvl = src_lvl[i];
                best_vec = src_vec[i];
                best_irl = (i == 0);
            end
        end
        win_any = nmi_pend | (best_lvl != 4'h0);
        win_lvl = nmi_pend ? 4'hF   : best_lvl;
        win_vec = nmi_pend ? 8'd11  : best_vec;
        win_irl = ~nmi_pend & best_irl;
    end

    always_ff @(posedge CLK) begin
        if (RST || soft_rst) begin
            state       <= IDLE;
            CPU_INT_REQ <= 1'b0;
            CPU_INT_LVL <= 4'h0;
            CPU_NMI     <= 1'b0;
            CPU_INT_VEC <= 8'h0;
            win_vec_q   <= 8'h0;
        end else if (CE_R) begin
            state       <= state_nx;
            CPU_INT_REQ <= req_nx;
            CPU_INT_LVL <= lvl_nx;
            CPU_NMI     <= nmi_nx;
            CPU_INT_VEC <= vec_nx;
            win_vec_q   <= wvec_nx;
        end
    end

    // ACK latches the winner registered on the previous CE_R, so a source
    // dropping on the ACK edge still gets its own vector
    always_comb begin
        state_nx = state;
        req_nx   = CPU_INT_REQ;
        lvl_nx   = CPU_INT_LVL;
        nmi_nx   = CPU_NMI;
        vec_nx   = CPU_INT_VEC;
        wvec_nx  = win_vec_q;
        nmi_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nx = PEND;
                    req_nx   = 1'b1;
                    lvl_nx   = win_lvl;
                    nmi_nx   = nmi_pend;
                    wvec_nx  = win_vec;
                end
            end
            PEND: begin
                if (CPU_INT_ACK) begin
                    state_nx = ACKED;
                    vec_nx   = ack_vec;
                    nmi_clr  = CPU_NMI;
                end else if (!win_any) begin
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    lvl_nx   = 4'h0;
                    nmi_nx   = 1'b0;
                end else begin
                    lvl_nx   = win_lvl;
                    nmi_nx   = nmi_pend;
                    wvec_nx  = win_vec;
                end
            end
            ACKED: begin
                if (!CPU_INT_ACK) begin
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    lvl_nx   = 4'h0;
                    nmi_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sh7604_intc.sv
// Directed bench for sh7604_intc: register access, arbitration, NMI and the ACK handshake.
module tb_sh7604_intc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ce_ph = 1'b0;
    logic        CE_R, CE_F;
    logic        RES_N = 1'b1;
    logic [31:0] IBUS_A = 32'h0, IBUS_DI = 32'h0;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA = 4'h0;
    logic        IBUS_WE = 1'b0, IBUS_REQ = 1'b0;
    logic        IBUS_BUSY, IBUS_ACT;
    logic        NMI_N = 1'b1;
    logic [3:0]  IRL_N = 4'hF;
    logic        DIVU_IRQ = 0, DMAC0_IRQ = 0, DMAC1_IRQ = 0, WDT_IRQ = 0, SCI_IRQ = 0, FRT_IRQ = 0;
    logic [7:0]  DIVU_VEC = 8'h40, DMAC0_VEC = 8'h60, DMAC1_VEC = 8'h61;
    logic [7:0]  WDT_VEC = 8'h70, SCI_VEC = 8'h50, FRT_VEC = 8'h55;
    logic        CPU_INT_REQ, CPU_NMI;
    logic [3:0]  CPU_INT_LVL;
    logic        CPU_INT_ACK = 1'b0;
    logic [7:0]  CPU_INT_VEC;
`ifdef SH7604_INTC_EXTVEC_EN
    logic [7:0]  ext_vec = 8'h99;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) ce_ph <= ~ce_ph;
    assign CE_R = ce_ph;
    assign CE_F = ~ce_ph;

    sh7604_intc #(.IRL_SYNC(2)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .NMI_N(NMI_N), .IRL_N(IRL_N),
        .DIVU_IRQ(DIVU_IRQ), .DIVU_VEC(DIVU_VEC),
        .DMAC0_IRQ(DMAC0_IRQ), .DMAC0_VEC(DMAC0_VEC),
        .DMAC1_IRQ(DMAC1_IRQ), .DMAC1_VEC(DMAC1_VEC),
        .WDT_IRQ(WDT_IRQ), .WDT_VEC(WDT_VEC),
        .SCI_IRQ(SCI_IRQ), .SCI_VEC(SCI_VEC),
        .FRT_IRQ(FRT_IRQ), .FRT_VEC(FRT_VEC),
`ifdef SH7604_INTC_EXTVEC_EN
        .EXT_VEC(ext_vec),
`endif
        .CPU_INT_REQ(CPU_INT_REQ), .CPU_INT_LVL(CPU_INT_LVL), .CPU_NMI(CPU_NMI),
        .CPU_INT_ACK(CPU_INT_ACK), .CPU_INT_VEC(CPU_INT_VEC)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick_r();
        do @(posedge CLK); while (CE_R !== 1'b1);
        #1;
    endtask

    task automatic tick_f();
        do @(posedge CLK); while (CE_F !== 1'b1);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_r();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        tick_r();
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1; IBUS_BA = 4'hF;
        tick_f();
        chk(tag, IBUS_DO, exp);
        IBUS_REQ = 1'b0;
    endtask

    task automatic cpu_out(input string tag, input logic req, input logic [3:0] lvl, input logic nmi);
        chk({tag, "_req"}, {31'b0, CPU_INT_REQ}, {31'b0, req});
        chk({tag, "_lvl"}, {28'b0, CPU_INT_LVL}, {28'b0, lvl});
        chk({tag, "_nmi"}, {31'b0, CPU_NMI}, {31'b0, nmi});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge CLK);
        #1 RST = 1'b0;

        cpu_out("reset", 1'b0, 4'h0, 1'b0);
        chk("reset_vec", {24'b0, CPU_INT_VEC}, 32'h0);
        chk("busy", {31'b0, IBUS_BUSY}, 32'h0);
        IBUS_A = 32'hFFFFFEE2; IBUS_REQ = 1'b1; #1;
        chk("act_icr", {31'b0, IBUS_ACT}, 32'h1);
        IBUS_A = 32'hFFFFFE00; #1;
        chk("act_other", {31'b0, IBUS_ACT}, 32'h0);
        IBUS_REQ = 1'b0;
        rd("rd_icr_init", 32'hFFFFFEE0, 32'h80000000);
        rd("rd_iprb_init", 32'hFFFFFE60, 32'h0);
        rd("rd_unmapped", 32'hFFFFFE00, 32'h0);

        // masked source: IPR=0
        DIVU_IRQ = 1'b1; ticks(2);
        chk("masked_req", {31'b0, CPU_INT_REQ}, 32'h0);
        DIVU_IRQ = 1'b0;

        // basic DIVU request and handshake
        wr(32'hFFFFFEE0, 32'h00008000, 4'b0011);
        rd("rd_ipra", 32'hFFFFFEE0, 32'h80008000);
        DIVU_IRQ = 1'b1; tick_r();
        cpu_out("divu", 1'b1, 4'h8, 1'b0);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("divu_vec", {24'b0, CPU_INT_VEC}, 32'h40);
        chk("acked_req", {31'b0, CPU_INT_REQ}, 32'h1);
        CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0; tick_r();
        chk("divu_idle", {31'b0, CPU_INT_REQ}, 32'h0);
        CPU_INT_ACK = 1'b1; ticks(2);
        chk("ack_idle_req", {31'b0, CPU_INT_REQ}, 32'h0);
        chk("ack_idle_vec", {24'b0, CPU_INT_VEC}, 32'h40);
        CPU_INT_ACK = 1'b0;

        // equal levels: DIVU beats FRT, then IPRA=0 hands it to FRT
        wr(32'hFFFFFEE0, 32'h00005000, 4'b0011);
        wr(32'hFFFFFE60, 32'h05000000, 4'b1100);
        rd("rd_iprb", 32'hFFFFFE60, 32'h05000000);
        DIVU_IRQ = 1'b1; FRT_IRQ = 1'b1; tick_r();
        cpu_out("tie5", 1'b1, 4'h5, 1'b0);
        wr(32'hFFFFFEE0, 32'h00000000, 4'b0011);
        tick_r();
        chk("frt_lvl", {28'b0, CPU_INT_LVL}, 32'h5);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("frt_vec", {24'b0, CPU_INT_VEC}, 32'h55);
        CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0; FRT_IRQ = 1'b0; tick_r();

        // IRL level 9 ties DIVU at 9 and wins, autovector 64+4
        wr(32'hFFFFFEE0, 32'h00009000, 4'b0011);
        DIVU_IRQ = 1'b1; IRL_N = 4'h6; ticks(4);
        cpu_out("irl9", 1'b1, 4'h9, 1'b0);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("irl_vec", {24'b0, CPU_INT_VEC}, 32'd68);
        CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0; IRL_N = 4'hF; ticks(4);
        chk("irl_idle", {31'b0, CPU_INT_REQ}, 32'h0);

        // NMI falling edge preempts pending DIVU
        DIVU_IRQ = 1'b1; tick_r();
        chk("pre_nmi_lvl", {28'b0, CPU_INT_LVL}, 32'h9);
        NMI_N = 1'b0; ticks(5);
        cpu_out("nmi", 1'b1, 4'hF, 1'b1);
        rd("rd_nmil_low", 32'hFFFFFEE0, 32'h00009000);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("nmi_vec", {24'b0, CPU_INT_VEC}, 32'd11);
        CPU_INT_ACK = 1'b0; tick_r();
        cpu_out("nmi_done", 1'b0, 4'h0, 1'b0);
        tick_r();
        cpu_out("after_nmi", 1'b1, 4'h9, 1'b0);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("after_nmi_vec", {24'b0, CPU_INT_VEC}, 32'h40);
        CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0; tick_r();
        NMI_N = 1'b1; ticks(5);
        chk("nmi_rise_ignored", {31'b0, CPU_INT_REQ}, 32'h0);

        // higher request replaces lower before ACK
        wr(32'hFFFFFEE0, 32'h00003700, 4'b0011);
        DIVU_IRQ = 1'b1; tick_r();
        chk("lvl3", {28'b0, CPU_INT_LVL}, 32'h3);
        DMAC0_IRQ = 1'b1; tick_r();
        chk("lvl7", {28'b0, CPU_INT_LVL}, 32'h7);
        CPU_INT_ACK = 1'b1; tick_r();
        chk("dmac0_vec", {24'b0, CPU_INT_VEC}, 32'h60);
        CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0; DMAC0_IRQ = 1'b0; tick_r();

        // DMAC0 beats DMAC1 on a tie
        DMAC1_IRQ = 1'b1; DMAC0_IRQ = 1'b1; tick_r();
        CPU_INT_ACK = 1'b1; tick_r();
        chk("dma_tie_vec", {24'b0, CPU_INT_VEC}, 32'h60);
        CPU_INT_ACK = 1'b0; DMAC0_IRQ = 1'b0; DMAC1_IRQ = 1'b0; tick_r();

        // ACK and source drop on the same edge
        DIVU_IRQ = 1'b1; tick_r();
        CPU_INT_ACK = 1'b1; DIVU_IRQ = 1'b0; tick_r();
        chk("ackdrop_vec", {24'b0, CPU_INT_VEC}, 32'h40);
        chk("ackdrop_req", {31'b0, CPU_INT_REQ}, 32'h1);
        CPU_INT_ACK = 1'b0; tick_r();
        chk("ackdrop_idle", {31'b0, CPU_INT_REQ}, 32'h0);

        // sync reset while ACKED
        DIVU_IRQ = 1'b1; tick_r();
        CPU_INT_ACK = 1'b1; tick_r();
        RST = 1'b1; @(posedge CLK); #1;
        cpu_out("rst_acked", 1'b0, 4'h0, 1'b0);
        chk("rst_vec", {24'b0, CPU_INT_VEC}, 32'h0);
        RST = 1'b0; CPU_INT_ACK = 1'b0; DIVU_IRQ = 1'b0;
        rd("rd_after_rst", 32'hFFFFFEE0, 32'h80000000);

        // soft reset clears registers; unused IPRA bits read 0
        wr(32'hFFFFFEE0, 32'h00001234, 4'b0011);
        rd("rd_ipra_bits", 32'hFFFFFEE0, 32'h80001230);
        RES_N = 1'b0; tick_r(); RES_N = 1'b1;
        rd("rd_after_res_n", 32'hFFFFFEE0, 32'h80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
